nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
Digit-serial WIDTH-bit adder built on the team's 4-bit carry-lookahead slice. It accepts full-width operands over a valid/ready handshake and feeds the slice one nibble per cycle, least significant nibble first. The carry is held in a register between nibbles. The result is presented on a second valid/ready handshake. It sits directly upstream of the slice: it drives the slice's A, B and Cin, and consumes its S and Cout.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8
NNIB, WIDTH/4 (derived, not overridable), number of nibble steps per add

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
cin  input  1  carry-in, sampled on accept
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  unsigned carry out of bit WIDTH-1
overflow  output  1  two's-complement signed overflow

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- FSM states: IDLE, RUN, DONE.
- Reset (async assert) forces:
  - state=IDLE, step counter=0, carry register=0;
  - operand shift registers, sum register, cout and overflow all cleared to 0;
  - hence in_ready=1 and out_valid=0 while in reset and after release.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from state only; no combinational path from in_valid or out_ready.
- IDLE:
  - on a rising edge with in_valid=1, latch a and b into shift registers, carry<=cin, cnt<=0, latch a[WIDTH-1] and b[WIDTH-1];
  - go to RUN.
- RUN, each cycle:
  - slice inputs are A=a_sh[3:0], B=b_sh[3:0], Cin=carry;
  - on the edge: a_sh>>=4, b_sh>>=4, sum_sh<={S,sum_sh[WIDTH-1:4]}, carry<=slice Cout, cnt<=cnt+1;
  - when cnt==NNIB-1, the same edge moves to DONE, loads cout<=slice Cout and loads overflow.
- overflow = (a_msb==b_msb) && (final sum[WIDTH-1]!=a_msb). cin does not enter this formula beyond its effect on sum.
- DONE:
  - sum, cout and overflow are held stable while out_valid=1 and out_ready=0, for any number of cycles;
  - on an edge with out_ready=1, go to IDLE. sum, cout and overflow keep their values until the next DONE load.
- Latency: the accept edge is edge 0, and out_valid rises after edge NNIB (4 cycles for WIDTH=16). Throughput is one add per NNIB+2 cycles minimum. There is no overlap: in_ready stays 0 during the DONE->IDLE cycle.
- in_valid while in RUN or DONE is ignored; operands are not sampled.
- out_ready is ignored outside DONE.
- rst asserted mid-RUN or in DONE: the partial result is discarded, all state is cleared immediately, and no out_valid pulse occurs.
- The step counter is $clog2(NNIB) bits wide and never wraps past NNIB-1.

Decomposition:
- Shared package adder_pkg holds the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and NIBBLE=4.
- One sub-module instance: cla_block, the 4-bit CLA slice, instantiated once and reused every RUN cycle.
- All control, shift registers and the carry register live in nibble_serial_adder.

Test Plan:
- Basic add, WIDTH=16: a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid 4 cycles after accept; sum=0x5555, cout=0, overflow=0.
- Carry ripple across all nibbles: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- Signed overflow:
  - a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1;
  - a=0x8000, b=0x8000 -> sum=0x0000, cout=1, overflow=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> sum, cout and overflow stable and out_valid held high. Meanwhile in_valid pulsed with a=0x1111 must not be accepted and in_ready stays 0. Raise out_ready -> IDLE next cycle.
- Reset mid-operation: assert rst asynchronously after 2 RUN cycles -> in_ready=1, out_valid=0, sum=0 immediately. A new add of 0x00FF+0x0001 then yields 0x0100 with no stale carry.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and slice width.
`timescale 1ns/1ps
package adder_pkg;

    // Width of one carry-lookahead slice, in bits.
    localparam int unsigned NIBBLE = 4;

    // Control FSM of the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_block.sv
// 4-bit carry-lookahead adder slice: all carries formed from generate/propagate
// terms in parallel, no internal ripple.
`timescale 1ns/1ps
module cla_block
    import adder_pkg::*;
(
    input  logic [NIBBLE-1:0] a_i,
    input  logic [NIBBLE-1:0] b_i,
    input  logic              cin_i,
    output logic [NIBBLE-1:0] s_o,
    output logic              cout_o
);

    logic [NIBBLE-1:0] g;
    logic [NIBBLE-1:0] p;
    logic [NIBBLE:0]   c;

    // Lookahead carries and per-bit sums.
    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c[0] = cin_i;
        c[1] = g[0] | (p[0] & cin_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin_i);
        s_o    = p ^ c[NIBBLE-1:0];
        cout_o = c[NIBBLE];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder: one nibble per cycle through a single CLA slice,
// LS nibble first, carry kept in a register between nibbles. Operands and result
// each use a valid/ready handshake.
`timescale 1ns/1ps
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NNIB = WIDTH / NIBBLE;
    localparam int unsigned CNTW = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [CNTW-1:0] LAST_STEP = CNTW'(NNIB - 1);

    state_e            state_q;
    logic [CNTW-1:0]   cnt_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_sh_q;
    logic [WIDTH-1:0]  b_sh_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              a_msb_q;
    logic              b_msb_q;

    logic [NIBBLE-1:0] slice_s;
    logic              slice_cout;

    cla_block u_cla (
        .a_i    (a_sh_q[NIBBLE-1:0]),
        .b_i    (b_sh_q[NIBBLE-1:0]),
        .cin_i  (carry_q),
        .s_o    (slice_s),
        .cout_o (slice_cout)
    );

    // Control FSM plus the datapath registers it sequences.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> NIBBLE;
                    b_sh_q  <= b_sh_q >> NIBBLE;
                    sum_q   <= {slice_s, sum_q[WIDTH-1:NIBBLE]};
                    carry_q <= slice_cout;
                    if (cnt_q == LAST_STEP) begin
                        // Final nibble: its top sum bit is the result MSB.
                        cout_q  <= slice_cout;
                        ovf_q   <= (a_msb_q == b_msb_q) && (slice_s[NIBBLE-1] != a_msb_q);
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake flags decode purely from state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
        overflow  = ovf_q;
    end

endmodule
